// File: rtl/lane_phase_scheduler.sv
// lane_phase_scheduler
//
// Four-lane intersection phase scheduler. Two conflicting lane pairs are
// sequenced through green, yellow and all-red phases:
//   pair A = lanes 2 and 4 (bits 1 and 3), the rest phase
//   pair B = lanes 1 and 3 (bits 0 and 2)
// Raw car sensors are synchronised and latched into per-lane waiting flags.
// Green time follows minimum-green, gap-out and maximum-green rules, and the
// twelve lamp outputs are decoded directly from the state register.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   car_req[3:0] in   raw asynchronous car sensors, bit n-1 = lane n
//   lane_red     out  red lamp per lane
//   lane_yellow  out  yellow lamp per lane
//   lane_green   out  green lamp per lane
//   phase[2:0]   out  current state encoding
//   waiting[3:0] out  latched per-lane service requests
module lane_phase_scheduler #(
    parameter logic [23:0] TICK_DIV  = 24'd12_000_000,
    parameter logic [7:0]  MIN_GREEN = 8'd4,
    parameter logic [7:0]  MAX_GREEN = 8'd15,
    parameter logic [7:0]  YELLOW_T  = 8'd2,
    parameter logic [7:0]  ALLRED_T  = 8'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] car_req,
    output logic [3:0] lane_red,
    output logic [3:0] lane_yellow,
    output logic [3:0] lane_green,
    output logic [2:0] phase,
    output logic [3:0] waiting
);

    typedef enum logic [2:0] {
        GREEN_A  = 3'd0,
        YELLOW_A = 3'd1,
        RED_AB   = 3'd2,
        GREEN_B  = 3'd3,
        YELLOW_B = 3'd4,
        RED_BA   = 3'd5
    } state_t;

    localparam logic [3:0] PAIR_A = 4'b1010;
    localparam logic [3:0] PAIR_B = 4'b0101;

    state_t      state_q, state_d;
    logic [3:0]  sync1_q, sync1_d;
    logic [3:0]  sync2_q, sync2_d;
    logic [3:0]  waiting_q, waiting_d;
    logic [23:0] presc_q, presc_d;
    logic [7:0]  timer_q, timer_d;

    logic        tick;
    logic [8:0]  tn;
    logic        state_change;
    logic        go_a, go_b;

    // Lamp decode straight from the state register.
    always_comb begin
        lane_green  = 4'b0000;
        lane_yellow = 4'b0000;
        lane_red    = 4'b1111;
        case (state_q)
            GREEN_A:  begin lane_green  = PAIR_A; lane_red = PAIR_B; end
            YELLOW_A: begin lane_yellow = PAIR_A; lane_red = PAIR_B; end
            GREEN_B:  begin lane_green  = PAIR_B; lane_red = PAIR_A; end
            YELLOW_B: begin lane_yellow = PAIR_B; lane_red = PAIR_A; end
            default:  lane_red = 4'b1111;
        endcase
    end

    always_comb begin
        tick = (presc_q == (TICK_DIV - 24'd1));
        // tn is 9 bits so a saturated timer (255) still compares as 256.
        tn   = {1'b0, timer_q} + 9'd1;

        // A green ends only if the opposing pair is waiting, and then either
        // at max green or at min green once its own lanes have gone quiet.
        go_a = ((waiting_q & PAIR_B) != 4'b0000) &&
               ((tn >= {1'b0, MAX_GREEN}) ||
                ((tn >= {1'b0, MIN_GREEN}) && ((sync2_q & PAIR_A) == 4'b0000)));
        go_b = ((waiting_q & PAIR_A) != 4'b0000) &&
               ((tn >= {1'b0, MAX_GREEN}) ||
                ((tn >= {1'b0, MIN_GREEN}) && ((sync2_q & PAIR_B) == 4'b0000)));

        state_d = state_q;
        case (state_q)
            GREEN_A:  if (tick && go_a) state_d = YELLOW_A;
            YELLOW_A: if (tick && (tn == {1'b0, YELLOW_T})) state_d = RED_AB;
            RED_AB:   if (tick && (tn == {1'b0, ALLRED_T})) state_d = GREEN_B;
            GREEN_B:  if (tick && go_b) state_d = YELLOW_B;
            YELLOW_B: if (tick && (tn == {1'b0, YELLOW_T})) state_d = RED_BA;
            RED_BA:   if (tick && (tn == {1'b0, ALLRED_T})) state_d = GREEN_A;
            default:  state_d = GREEN_A;
        endcase

        state_change = (state_d != state_q);

        // Restarting the prescaler on entry makes every timed state last an
        // exact multiple of TICK_DIV cycles.
        presc_d = (state_change || tick) ? 24'd0 : presc_q + 24'd1;

        if (state_change) begin
            timer_d = 8'd0;
        end else if (tick && (timer_q != 8'hFF)) begin
            timer_d = timer_q + 8'd1;
        end else begin
            timer_d = timer_q;
        end

        // Green lanes never latch a request; entering a pair's green clears
        // that pair, and the clear overrides a same-cycle set.
        waiting_d = waiting_q | (sync2_q & ~lane_green);
        if (state_change && (state_d == GREEN_A)) waiting_d = waiting_d & ~PAIR_A;
        if (state_change && (state_d == GREEN_B)) waiting_d = waiting_d & ~PAIR_B;

        sync1_d = car_req;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= GREEN_A;
            sync1_q   <= 4'b0000;
            sync2_q   <= 4'b0000;
            waiting_q <= 4'b0000;
            presc_q   <= 24'd0;
            timer_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            waiting_q <= waiting_d;
            presc_q   <= presc_d;
            timer_q   <= timer_d;
        end
    end

    assign phase   = state_q;
    assign waiting = waiting_q;

endmodule

// File: tb/tb_lane_phase_scheduler.sv
module tb_lane_phase_scheduler;

    localparam logic [23:0] TD   = 24'd4;
    localparam logic [7:0]  MING = 8'd2;
    localparam logic [7:0]  MAXG = 8'd5;
    localparam logic [7:0]  YT   = 8'd2;
    localparam logic [7:0]  AR   = 8'd1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] car_req = 4'b0000;
    logic [3:0] lane_red, lane_yellow, lane_green, waiting;
    logic [2:0] phase;

    always #5 clk = ~clk;

    lane_phase_scheduler #(
        .TICK_DIV (TD),
        .MIN_GREEN(MING),
        .MAX_GREEN(MAXG),
        .YELLOW_T (YT),
        .ALLRED_T (AR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .car_req    (car_req),
        .lane_red   (lane_red),
        .lane_yellow(lane_yellow),
        .lane_green (lane_green),
        .phase      (phase),
        .waiting    (waiting)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: tracks the phase and cycles spent in it; ticks and
    // elapsed tick counts are derived arithmetically from that cycle count.
    logic [2:0] m_ph   = 3'd0;
    int         m_cyc  = 0;
    logic [3:0] m_s1   = 4'b0000;
    logic [3:0] m_s2   = 4'b0000;
    logic [3:0] m_wait = 4'b0000;

    function automatic logic [3:0] grn_of(input logic [2:0] p);
        case (p)
            3'd0:    return 4'b1010;
            3'd3:    return 4'b0101;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] yel_of(input logic [2:0] p);
        case (p)
            3'd1:    return 4'b1010;
            3'd4:    return 4'b0101;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] red_of(input logic [2:0] p);
        case (p)
            3'd0, 3'd1: return 4'b0101;
            3'd3, 3'd4: return 4'b1010;
            default:    return 4'b1111;
        endcase
    endfunction

    task automatic model_step(input logic r, input logic [3:0] req);
        int         ticks, tn;
        bit         is_tick;
        logic [2:0] nph;
        logic [3:0] nw;
        if (r) begin
            m_ph = 3'd0; m_cyc = 0; m_s1 = 4'b0000; m_s2 = 4'b0000; m_wait = 4'b0000;
            return;
        end
        ticks   = m_cyc / int'(TD);
        is_tick = (m_cyc % int'(TD)) == int'(TD) - 1;
        tn      = ((ticks > 255) ? 255 : ticks) + 1;
        nph     = m_ph;
        if (is_tick) begin
            case (m_ph)
                3'd0: if ((m_wait & 4'b0101) != 0 &&
                          (tn >= int'(MAXG) || (tn >= int'(MING) && (m_s2 & 4'b1010) == 0))) nph = 3'd1;
                3'd1: if (tn == int'(YT)) nph = 3'd2;
                3'd2: if (tn == int'(AR)) nph = 3'd3;
                3'd3: if ((m_wait & 4'b1010) != 0 &&
                          (tn >= int'(MAXG) || (tn >= int'(MING) && (m_s2 & 4'b0101) == 0))) nph = 3'd4;
                3'd4: if (tn == int'(YT)) nph = 3'd5;
                3'd5: if (tn == int'(AR)) nph = 3'd0;
                default: nph = 3'd0;
            endcase
        end
        nw = m_wait | (m_s2 & ~grn_of(m_ph));
        if (nph != m_ph && nph == 3'd3) nw = nw & 4'b1010;
        if (nph != m_ph && nph == 3'd0) nw = nw & 4'b0101;
        m_s2   = m_s1;
        m_s1   = req;
        m_cyc  = (nph != m_ph) ? 0 : m_cyc + 1;
        m_ph   = nph;
        m_wait = nw;
    endtask

    // One clock: the model consumes the inputs present at the edge, then the
    // DUT outputs are compared 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_step(rst, car_req);
        #1;
        chk("model phase",   32'(phase),       32'(m_ph));
        chk("model green",   32'(lane_green),  32'(grn_of(m_ph)));
        chk("model yellow",  32'(lane_yellow), 32'(yel_of(m_ph)));
        chk("model red",     32'(lane_red),    32'(red_of(m_ph)));
        chk("model waiting", 32'(waiting),     32'(m_wait));
    endtask

    // Leaves the bench at the start of cycle 0 with rst low.
    task automatic do_reset();
        rst = 1'b1;
        car_req = 4'b0000;
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        int         scen;
        int         cyc;
        logic [3:0] req;
        logic [2:0] ph;
        logic [3:0] grn;
        logic [3:0] wt;
    } vec_t;

    vec_t vec [22];
    int   last_cyc [2];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] m;

        // scenario 0: single request, gap-out; scenario 1: max green
        vec = '{
            '{0,  0, 4'b0001, 3'd0, 4'b1010, 4'b0000},
            '{0,  2, 4'b0000, 3'd0, 4'b1010, 4'b0000},
            '{0,  3, 4'b0000, 3'd0, 4'b1010, 4'b0001},
            '{0,  7, 4'b0000, 3'd0, 4'b1010, 4'b0001},
            '{0,  8, 4'b0000, 3'd1, 4'b0000, 4'b0001},
            '{0, 15, 4'b0000, 3'd1, 4'b0000, 4'b0001},
            '{0, 16, 4'b0000, 3'd2, 4'b0000, 4'b0001},
            '{0, 19, 4'b0000, 3'd2, 4'b0000, 4'b0001},
            '{0, 20, 4'b0000, 3'd3, 4'b0101, 4'b0000},
            '{0, 44, 4'b0000, 3'd3, 4'b0101, 4'b0000},
            '{1,  0, 4'b0110, 3'd0, 4'b1010, 4'b0000},
            '{1,  2, 4'b0010, 3'd0, 4'b1010, 4'b0000},
            '{1,  3, 4'b0010, 3'd0, 4'b1010, 4'b0100},
            '{1, 19, 4'b0010, 3'd0, 4'b1010, 4'b0100},
            '{1, 20, 4'b0010, 3'd1, 4'b0000, 4'b0100},
            '{1, 21, 4'b0010, 3'd1, 4'b0000, 4'b0110},
            '{1, 28, 4'b0010, 3'd2, 4'b0000, 4'b0110},
            '{1, 31, 4'b0010, 3'd2, 4'b0000, 4'b0110},
            '{1, 32, 4'b0010, 3'd3, 4'b0101, 4'b0010},
            '{1, 39, 4'b0010, 3'd3, 4'b0101, 4'b0010},
            '{1, 40, 4'b0010, 3'd4, 4'b0000, 4'b0010},
            '{1, 41, 4'b0010, 3'd4, 4'b0000, 4'b0010}
        };
        last_cyc[0] = 44;
        last_cyc[1] = 41;

        // Reset state
        rst = 1'b1;
        car_req = 4'b0000;
        step();
        step();
        chk("reset phase",   32'(phase),       32'd0);
        chk("reset green",   32'(lane_green),  32'hA);
        chk("reset red",     32'(lane_red),    32'h5);
        chk("reset yellow",  32'(lane_yellow), 32'h0);
        chk("reset waiting", 32'(waiting),     32'h0);

        // Idle: nothing moves for 200 cycles
        do_reset();
        for (int c = 0; c < 200; c++) begin
            chk("idle", 32'({phase, lane_green, lane_red, waiting}),
                32'({3'd0, 4'b1010, 4'b0101, 4'b0000}));
            step();
        end

        // Table-driven scenarios
        for (int s = 0; s < 2; s++) begin
            do_reset();
            for (int c = 0; c <= last_cyc[s]; c++) begin
                for (int k = 0; k < 22; k++) begin
                    if (vec[k].scen == s && vec[k].cyc == c) begin
                        car_req = vec[k].req;
                        chk($sformatf("s%0d c%0d phase", s, c),   32'(phase),      32'(vec[k].ph));
                        chk($sformatf("s%0d c%0d green", s, c),   32'(lane_green), 32'(vec[k].grn));
                        chk($sformatf("s%0d c%0d waiting", s, c), 32'(waiting),    32'(vec[k].wt));
                    end
                end
                step();
            end
        end

        // Reset mid-yellow: now in cycle 42 of scenario 1, inside YELLOW_B
        chk("pre-reset in YELLOW_B", 32'(phase), 32'd4);
        rst = 1'b1;
        car_req = 4'b0001;
        step();
        chk("rst-mid-yellow phase",   32'(phase),      32'd0);
        chk("rst-mid-yellow green",   32'(lane_green), 32'hA);
        chk("rst-mid-yellow waiting", 32'(waiting),    32'h0);
        rst = 1'b0;
        n = 0;
        while (phase == 3'd0 && n < 60) begin
            if (n == 2) car_req = 4'b0000;
            step();
            n++;
        end
        chk("rst-mid-yellow transition seen", 32'(phase == 3'd1), 32'd1);
        chk("rst-mid-yellow held >= 2 ticks", 32'(n >= 8), 32'd1);

        // Green-lane sensor ignored
        do_reset();
        car_req = 4'b1000;
        for (int c = 0; c < 60; c++) begin
            step();
            chk("green-lane waiting[3]", 32'(waiting[3]), 32'd0);
            chk("green-lane phase",      32'(phase),      32'd0);
        end

        // Set/clear collision: sync[0] first high in the RED_AB -> GREEN_B cycle
        do_reset();
        for (int c = 0; c <= 25; c++) begin
            if (c == 0) car_req = 4'b0100;
            if (c == 2) car_req = 4'b0000;
            if (c == 17) car_req = 4'b0001;
            if (c == 19) begin
                chk("collision pre phase",   32'(phase),   32'd2);
                chk("collision pre waiting", 32'(waiting), 32'h4);
            end
            if (c == 20) begin
                chk("collision phase",   32'(phase),   32'd3);
                chk("collision waiting", 32'(waiting), 32'h0);
            end
            if (c == 25) chk("collision waiting later", 32'(waiting), 32'h0);
            step();
        end

        // Randomized stimulus against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            m = 4'b0000;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) m[b] = 1'b1;
            car_req = car_req ^ m;
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
